// File: rtl/sdram_line_fetcher.sv
// Fetches one line from SDRAM as a sequence of 8-word burst reads and streams
// the returned words out one at a time, checking each burst's address tag.
module sdram_line_fetcher #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [23:0]          base_addr_i,
    input  logic [LEN_WIDTH-1:0] num_bursts_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [31:0]          cmd_burst_d_o,
    output logic                 cmd_burst_enq_o,
    input  logic                 cmd_burst_alm_full_i,
    input  logic [159:0]         rsp_burst_q_i,
    input  logic                 rsp_burst_empty_i,
    output logic                 rsp_burst_deq_o,
    output logic [15:0]          pix_d_o,
    output logic                 pix_valid_o,
    input  logic                 pix_ready_i,
    output logic                 pix_last_o
);

    // Return-path states
    //   state   | meaning
    //   R_IDLE  | waiting for a burst at the head of the data FIFO
    //   R_SHIFT | presenting the 8 words of the latched burst downstream

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        R_IDLE,
        R_SHIFT
    } ret_state_t;

    ret_state_t state, state_next;

    logic                 busy;
    logic                 done;
    logic                 error;
    logic [LEN_WIDTH-1:0] num_bursts;
    logic [LEN_WIDTH-1:0] issued;
    logic [LEN_WIDTH-1:0] returned;
    logic [OUT_W-1:0]     outstanding;
    logic [23:0]          issue_addr;
    logic [23:0]          tag_addr;
    logic                 cmd_enq;
    logic [31:0]          cmd_d;
    logic                 rsp_deq;
    logic [127:0]         shift;
    logic [2:0]           word_cnt;

    logic start_accept;
    logic issue_fire;
    logic fetch_burst;
    logic word_accept;
    logic last_word;
    logic pix_valid;
    logic pix_last;
    logic line_done;
    logic unused_rsp_bits;

    assign unused_rsp_bits = ^rsp_burst_q_i[159:152];

    assign start_accept = start_i && !busy;

    // The !cmd_enq term spaces enqueues at least one cycle apart.
    assign issue_fire = busy
                     && (issued < num_bursts)
                     && (outstanding < OUT_W'(MAX_OUTSTANDING))
                     && !cmd_burst_alm_full_i
                     && !cmd_enq;

    always_comb begin
        state_next  = state;
        fetch_burst = 1'b0;
        word_accept = 1'b0;
        last_word   = 1'b0;
        pix_valid   = 1'b0;
        pix_last    = 1'b0;
        case (state)
            R_IDLE: begin
                if (busy && !rsp_burst_empty_i && (returned < num_bursts)) begin
                    fetch_burst = 1'b1;
                    state_next  = R_SHIFT;
                end
            end
            R_SHIFT: begin
                pix_valid   = 1'b1;
                last_word   = (word_cnt == 3'd7);
                pix_last    = last_word && (returned == num_bursts);
                word_accept = pix_ready_i;
                if (pix_ready_i && last_word) begin
                    state_next = R_IDLE;
                end
            end
            default: state_next = R_IDLE;
        endcase
    end

    assign line_done = word_accept && pix_last;

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            state <= R_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            num_bursts  <= '0;
            issued      <= '0;
            returned    <= '0;
            outstanding <= '0;
            issue_addr  <= '0;
            tag_addr    <= '0;
            cmd_enq     <= 1'b0;
            cmd_d       <= '0;
            rsp_deq     <= 1'b0;
            shift       <= '0;
            word_cnt    <= '0;
        end else begin
            done    <= 1'b0;
            cmd_enq <= issue_fire;
            rsp_deq <= fetch_burst;

            if (start_accept) begin
                error       <= 1'b0;
                num_bursts  <= num_bursts_i;
                issued      <= '0;
                returned    <= '0;
                outstanding <= '0;
                issue_addr  <= base_addr_i;
                tag_addr    <= base_addr_i;
                if (num_bursts_i == '0) begin
                    done <= 1'b1;
                end else begin
                    busy <= 1'b1;
                end
            end else begin
                if (issue_fire) begin
                    cmd_d      <= {8'h00, issue_addr};
                    issue_addr <= issue_addr + 24'd8;
                    issued     <= issued + LEN_WIDTH'(1);
                end

                case ({issue_fire, fetch_burst})
                    2'b10:   outstanding <= outstanding + OUT_W'(1);
                    2'b01:   outstanding <= outstanding - OUT_W'(1);
                    default: outstanding <= outstanding;
                endcase

                // A mismatching tag only flags the error; the data still goes out.
                if (fetch_burst) begin
                    shift    <= rsp_burst_q_i[127:0];
                    word_cnt <= 3'd0;
                    returned <= returned + LEN_WIDTH'(1);
                    tag_addr <= tag_addr + 24'd8;
                    if (rsp_burst_q_i[151:128] != tag_addr) begin
                        error <= 1'b1;
                    end
                end else if (word_accept) begin
                    shift    <= {shift[111:0], 16'h0000};
                    word_cnt <= word_cnt + 3'd1;
                end

                if (line_done) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

    assign busy_o          = busy;
    assign done_o          = done;
    assign error_o         = error;
    assign cmd_burst_d_o   = cmd_d;
    assign cmd_burst_enq_o = cmd_enq;
    assign rsp_burst_deq_o = rsp_deq;
    assign pix_d_o         = shift[127:112];
    assign pix_valid_o     = pix_valid;
    assign pix_last_o      = pix_last;

endmodule

// File: tb/tb_sdram_line_fetcher.sv
// Directed bench for sdram_line_fetcher with a show-ahead burst FIFO model that
// answers each command with a tagged burst whose words are addr[15:0]+j.
module tb_sdram_line_fetcher;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [23:0]  base_addr;
    logic [7:0]   num_bursts;
    logic         busy;
    logic         done;
    logic         error;
    logic [31:0]  cmd_d;
    logic         cmd_enq;
    logic         alm_full;
    logic [159:0] rsp_q = '0;
    logic         rsp_empty = 1'b1;
    logic         rsp_deq;
    logic [15:0]  pix_d;
    logic         pix_valid;
    logic         pix_ready;
    logic         pix_last;

    always #5 clk = ~clk;

    sdram_line_fetcher #(.MAX_OUTSTANDING(4), .LEN_WIDTH(8)) dut (
        .clk                  (clk),
        .rst_n_i              (rst_n),
        .start_i              (start),
        .base_addr_i          (base_addr),
        .num_bursts_i         (num_bursts),
        .busy_o               (busy),
        .done_o               (done),
        .error_o              (error),
        .cmd_burst_d_o        (cmd_d),
        .cmd_burst_enq_o      (cmd_enq),
        .cmd_burst_alm_full_i (alm_full),
        .rsp_burst_q_i        (rsp_q),
        .rsp_burst_empty_i    (rsp_empty),
        .rsp_burst_deq_o      (rsp_deq),
        .pix_d_o              (pix_d),
        .pix_valid_o          (pix_valid),
        .pix_ready_i          (pix_ready),
        .pix_last_o           (pix_last)
    );

    // FIFO model state
    logic [159:0] fifo[$];
    logic [23:0]  pending[$];
    bit           hold = 1'b0;
    int           rel_req = 0;
    int           rel_done = 0;
    int           resp_idx = 0;
    int           corrupt_at = -1;

    // Observations
    logic [31:0]  got_cmds[$];
    logic [15:0]  got_words[$];
    int           word_cyc[$];
    int           cyc = 0;
    int           done_cnt = 0;
    int           last_cnt = 0;
    int           last_idx = -1;
    int           last_bad = 0;
    int           b2b = 0;
    int           stall_seen = 0;
    int           stall_bad = 0;
    bit           prev_enq = 1'b0;
    bit           prev_stall = 1'b0;
    logic [15:0]  prev_d = '0;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [159:0] make_resp(input logic [23:0] addr, input bit bad);
        logic [159:0] e;
        e = '0;
        e[151:128] = bad ? (addr ^ 24'h000001) : addr;
        for (int j = 0; j < 8; j++) begin
            e[127 - 16*j -: 16] = addr[15:0] + 16'(j);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cmd_enq) begin
            got_cmds.push_back(cmd_d);
            if (prev_enq) b2b <= b2b + 1;
        end
        prev_enq <= cmd_enq;
        if (done) done_cnt <= done_cnt + 1;
        if (pix_valid && pix_ready) begin
            if (pix_last) begin
                last_cnt <= last_cnt + 1;
                last_idx <= got_words.size();
            end
            got_words.push_back(pix_d);
            word_cyc.push_back(cyc);
        end
        if (pix_last && !pix_valid) last_bad <= last_bad + 1;
        if (rst_n && prev_stall) begin
            stall_seen <= stall_seen + 1;
            if (!(pix_valid === 1'b1 && pix_d === prev_d)) stall_bad <= stall_bad + 1;
        end
        prev_stall <= pix_valid && !pix_ready && rst_n;
        prev_d     <= pix_d;

        if (!rst_n) begin
            fifo.delete();
            pending.delete();
        end else begin
            if (rsp_deq && fifo.size() > 0) void'(fifo.pop_front());
            if (cmd_enq) pending.push_back(cmd_d[23:0]);
            if (pending.size() > 0 && (!hold || rel_done < rel_req)) begin
                fifo.push_back(make_resp(pending.pop_front(), resp_idx == corrupt_at));
                resp_idx <= resp_idx + 1;
                if (hold) rel_done <= rel_done + 1;
            end
        end
        rsp_q     <= (fifo.size() > 0) ? fifo[0] : '0;
        rsp_empty <= (fifo.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [23:0] b, input logic [7:0] n);
        base_addr  = b;
        num_bursts = n;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        check({tag, " seen"}, 32'(done_cnt != d0), 32'd1);
        check({tag, " busy low"}, 32'(busy), 32'd0);
        tick(1);
    endtask

    task automatic check_words(input string tag, input int w0, input logic [23:0] b, input int n);
        int bad;
        bad = 0;
        check({tag, " count"}, 32'(got_words.size() - w0), 32'(8 * n));
        for (int i = 0; i < 8 * n && w0 + i < got_words.size(); i++) begin
            if (got_words[w0 + i] !== b[15:0] + 16'(i)) bad++;
        end
        check({tag, " data"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int c0, w0, l0, d0, b0, s0, sb0, bad;

        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        num_bursts = '0;
        alm_full   = 1'b0;
        pix_ready  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ctl", 32'({busy, done, error, cmd_enq, rsp_deq, pix_valid, pix_last}), 32'd0);
        check("reset pix_d", 32'(pix_d), 32'd0);
        check("reset cmd_d", cmd_d, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);

        // basic two-burst line, with a start pulse during busy that must be ignored
        c0 = got_cmds.size(); w0 = got_words.size(); l0 = last_cnt; d0 = done_cnt;
        do_start(24'h000100, 8'd2);
        check("A busy", 32'(busy), 32'd1);
        tick(4);
        base_addr = 24'h00FF00; num_bursts = 8'd1; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("A done", 200);
        check("A cmd count", 32'(got_cmds.size() - c0), 32'd2);
        check("A cmd0", got_cmds[c0], 32'h00000100);
        check("A cmd1", got_cmds[c0 + 1], 32'h00000108);
        check_words("A words", w0, 24'h000100, 2);
        check("A last count", 32'(last_cnt - l0), 32'd1);
        check("A last pos", 32'(last_idx), 32'(w0 + 15));
        check("A throughput", 32'((word_cyc[w0 + 15] - word_cyc[w0]) <= 16), 32'd1);
        tick(5);
        check("A done once", 32'(done_cnt - d0), 32'd1);
        check("A error", 32'(error), 32'd0);

        // address wrap at the top of the 24-bit space
        c0 = got_cmds.size(); w0 = got_words.size();
        do_start(24'hFFFFF8, 8'd2);
        wait_done("B done", 200);
        check("B cmd count", 32'(got_cmds.size() - c0), 32'd2);
        check("B cmd0", got_cmds[c0], 32'h00FFFFF8);
        check("B cmd1", got_cmds[c0 + 1], 32'h00000000);
        check_words("B words", w0, 24'hFFFFF8, 2);
        check("B error", 32'(error), 32'd0);

        // corrupted tag on the second response
        w0 = got_words.size();
        corrupt_at = resp_idx + 1;
        do_start(24'h000400, 8'd2);
        wait_done("C done", 200);
        check("C error", 32'(error), 32'd1);
        check_words("C words", w0, 24'h000400, 2);
        tick(10);
        check("C error sticky", 32'(error), 32'd1);
        corrupt_at = -1;

        // almost-full throttling; start also clears error
        c0 = got_cmds.size(); w0 = got_words.size(); b0 = b2b;
        alm_full = 1'b1;
        do_start(24'h000800, 8'd3);
        check("D error cleared", 32'(error), 32'd0);
        tick(20);
        check("D no cmd while full", 32'(got_cmds.size() - c0), 32'd0);
        check("D busy", 32'(busy), 32'd1);
        alm_full = 1'b0;
        wait_done("D done", 300);
        check("D cmd count", 32'(got_cmds.size() - c0), 32'd3);
        check("D cmd0", got_cmds[c0], 32'h00000800);
        check("D cmd2", got_cmds[c0 + 2], 32'h00000810);
        check("D back-to-back", 32'(b2b - b0), 32'd0);
        check_words("D words", w0, 24'h000800, 3);

        // outstanding limit with withheld responses
        c0 = got_cmds.size(); w0 = got_words.size(); l0 = last_cnt; b0 = b2b;
        hold = 1'b1;
        do_start(24'h001000, 8'd10);
        tick(30);
        check("E cmds at limit", 32'(got_cmds.size() - c0), 32'd4);
        rel_req = rel_req + 1;
        tick(8);
        check("E cmds after release", 32'(got_cmds.size() - c0), 32'd5);
        check("E cmd4", got_cmds[c0 + 4], 32'h00001020);
        hold = 1'b0;
        wait_done("E done", 600);
        check("E cmd count", 32'(got_cmds.size() - c0), 32'd10);
        check("E cmd9", got_cmds[c0 + 9], 32'h00001048);
        check_words("E words", w0, 24'h001000, 10);
        check("E last pos", 32'(last_idx), 32'(w0 + 79));
        check("E last count", 32'(last_cnt - l0), 32'd1);
        check("E back-to-back", 32'(b2b - b0), 32'd0);
        check("E error", 32'(error), 32'd0);

        // random back-pressure then reset mid-line
        w0 = got_words.size(); s0 = stall_seen; sb0 = stall_bad;
        do_start(24'h002000, 8'd2);
        for (int i = 0; i < 20; i++) begin
            pix_ready = (i % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            tick(1);
        end
        check("F stalls seen", 32'(stall_seen > s0), 32'd1);
        check("F stall stable", 32'(stall_bad - sb0), 32'd0);
        check("F partial line", 32'(got_words.size() - w0 < 16), 32'd1);
        bad = 0;
        for (int i = 0; w0 + i < got_words.size(); i++) begin
            if (got_words[w0 + i] !== 16'h2000 + 16'(i)) bad++;
        end
        check("F prefix data", 32'(bad), 32'd0);
        rst_n = 1'b0;
        pix_ready = 1'b1;
        tick(1);
        @(negedge clk);
        check("F reset ctl", 32'({busy, done, error, cmd_enq, rsp_deq, pix_valid, pix_last}), 32'd0);
        check("F reset pix_d", 32'(pix_d), 32'd0);
        check("F reset cmd_d", cmd_d, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);
        c0 = got_cmds.size();
        do_start(24'h003000, 8'd0);
        check("F zero done", 32'(done), 32'd1);
        check("F zero busy", 32'(busy), 32'd0);
        tick(1);
        check("F zero done pulse", 32'(done), 32'd0);
        tick(5);
        check("F zero no cmd", 32'(got_cmds.size() - c0), 32'd0);
        check("F zero idle", 32'(busy), 32'd0);

        check("last without valid", 32'(last_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
